// File: rtl/data_memory_sized_pkg.sv
// dm_pkg: shared encodings and helpers for the sized data memory.
//   - access size encodings (byte / half / word / reserved)
//   - FSM state encoding (sweep-clear vs. normal operation)
//   - lane_mask(): which byte lanes of a word a store touches
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Little-endian byte-lane enables for an access of size sz at byte offset a.
    // Misalignment is screened out by the caller; here half-words only look at a[1].
    function automatic logic [3:0] lane_mask(logic [1:0] sz, logic [1:0] a);
        logic [3:0] m;
        m = 4'b0000;
        case (sz)
            SZ_BYTE: m = 4'b0001 << a;
            SZ_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_mem_lane_unit.sv
// data_mem_lane_unit: purely combinational byte-lane steering.
//   Store side: wdata_i/size_i/addr_lo_i -> wmask_o (byte enables) and
//               wdata_sh_o (store data replicated onto every candidate lane).
//   Load side:  rword_i/size_i/addr_lo_i/unsigned_i -> rdata_o, the selected
//               byte/half/word, sign- or zero-extended to 32 bits.
module data_mem_lane_unit
    import dm_pkg::*;
(
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_sh_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign wmask_o = lane_mask(size_i, addr_lo_i);

    // Replicating the data onto all lanes lets the mask alone pick the target lanes.
    always_comb begin
        wdata_sh_o = wdata_i;
        case (size_i)
            SZ_BYTE: wdata_sh_o = {4{wdata_i[7:0]}};
            SZ_HALF: wdata_sh_o = {2{wdata_i[15:0]}};
            default: wdata_sh_o = wdata_i;
        endcase
    end

    always_comb begin
        rbyte = rword_i[7:0];
        case (addr_lo_i)
            2'd0: rbyte = rword_i[7:0];
            2'd1: rbyte = rword_i[15:8];
            2'd2: rbyte = rword_i[23:16];
            2'd3: rbyte = rword_i[31:24];
            default: rbyte = rword_i[7:0];
        endcase
        rhalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    always_comb begin
        rdata_o = rword_i;
        case (size_i)
            SZ_BYTE: rdata_o = unsigned_i ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
            SZ_HALF: rdata_o = unsigned_i ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
            default: rdata_o = rword_i;
        endcase
    end

endmodule

// File: rtl/data_memory_sized.sv
// data_memory_sized: MEM-stage data memory with byte/half/word accesses.
//   clock, reset (sync, active-high)
//   reqValid/reqReady   : access handshake; reqReady = !busy
//   address, writeEnabled, size, unsignedLoad, writeInput : access fields
//   readResult          : registered, extended load data (0 for stores/faults)
//   respValid, fault    : one-cycle response, one cycle after accept
//   busy                : post-reset clear sweep in progress
// After reset the array is zeroed one word per cycle; accesses are ignored
// until the sweep finishes (DEPTH cycles after reset deasserts).
module data_memory_sized
    import dm_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [ADDR_W-1:0] address,
    input  logic              writeEnabled,
    input  logic [1:0]        size,
    input  logic              unsignedLoad,
    input  logic [31:0]       writeInput,
    output logic [31:0]       readResult,
    output logic              respValid,
    output logic              fault,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             resp_vld_q, fault_q;
    logic [31:0]      rdata_q;

    logic             accept;
    logic             acc_fault;
    logic [IDX_W-1:0] idx;
    logic [3:0]       lu_mask;
    logic [31:0]      lu_wdata;
    logic [31:0]      lu_rdata;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_mask;
    logic [31:0]      wr_data;

    assign busy     = reset || (state_q == ST_CLEAR);
    assign reqReady = !busy;
    assign accept   = reqValid && reqReady;
    assign idx      = address[IDX_W+1:2];

    always_comb begin
        acc_fault = 1'b0;
        if ((address >> (IDX_W + 2)) != '0)              acc_fault = 1'b1;
        if (size == SZ_RSVD)                             acc_fault = 1'b1;
        if (size == SZ_HALF && address[0])               acc_fault = 1'b1;
        if (size == SZ_WORD && address[1:0] != 2'b00)    acc_fault = 1'b1;
    end

    data_mem_lane_unit u_lane (
        .wdata_i    (writeInput),
        .size_i     (size),
        .addr_lo_i  (address[1:0]),
        .unsigned_i (unsignedLoad),
        .rword_i    (mem_q[idx]),
        .wmask_o    (lu_mask),
        .wdata_sh_o (lu_wdata),
        .rdata_o    (lu_rdata)
    );

    // FSM: sweep runs through every index once, then parks in IDLE.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Single write port shared by the clear sweep and accepted stores.
    // accept already implies !busy, so the two sources never collide.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_mask = 4'b0000;
        wr_data = 32'h0;
        if (state_q == ST_CLEAR && !reset) begin
            wr_en   = 1'b1;
            wr_idx  = clr_idx_q;
            wr_mask = 4'b1111;
        end else if (accept && writeEnabled && !acc_fault) begin
            wr_en   = 1'b1;
            wr_mask = lu_mask;
            wr_data = lu_wdata;
        end
    end

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_mask[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // Response: readResult holds between responses; stores and faults zero it.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_vld_q <= 1'b0;
            fault_q    <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            resp_vld_q <= accept;
            fault_q    <= accept && acc_fault;
            if (accept) rdata_q <= (writeEnabled || acc_fault) ? 32'h0 : lu_rdata;
        end
    end

    assign respValid  = resp_vld_q;
    assign fault      = fault_q;
    assign readResult = rdata_q;

endmodule
